// File: rtl/reg_file_if.sv
// Read/write bus between the datapath and the integer register file.
// The datapath is the master: it drives the addresses and the write data, and the register file returns both read values.
interface reg_file_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              we3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] wa3;
  logic [XLEN-1:0]   wd3;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;

  modport master (
    output we3, ra1, ra2, wa3, wd3,
    input  rd1, rd2
  );

  modport slave (
    input  we3, ra1, ra2, wa3, wd3,
    output rd1, rd2
  );
endinterface

// File: rtl/reg_file.sv
// Integer register file for the single-cycle RISC-V datapath.
// It has two combinational read ports and one synchronous write port, and x0 always reads as zero.
module reg_file #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  reg_file_if.slave   bus
);
  localparam int NREGS = 2 ** ADDR_W;

  // x0 has no storage; the array starts at index 1.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  // NOTE: the array is cleared in a loop because it is a small flop array.
  // A RAM macro could not be cleared like this. Reset has priority, so a write in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.we3 && (bus.wa3 != '0)) begin
      r_regs[bus.wa3] <= bus.wd3;
    end
  end

  // No bypass: a read of the address being written returns the old value until the edge.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (bus.ra1 != '0) w_rd1 = r_regs[bus.ra1];
    if (bus.ra2 != '0) w_rd2 = r_regs[bus.ra2];
  end

  assign bus.rd1 = w_rd1;
  assign bus.rd2 = w_rd2;
endmodule

// File: tb/tb_reg_file.sv
// Directed-vector bench for reg_file.
// It covers reset, writes, x0 behaviour, read-during-write, the write enable, reset priority and a full readback sweep.
module tb_reg_file;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  reg_file_if #(.XLEN(32), .ADDR_W(5)) bus ();

  reg_file #(.XLEN(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Inputs change 1 ns after the rising edge, which keeps them away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] addr, input logic [31:0] data);
    bus.we3 = 1'b1;
    bus.wa3 = addr;
    bus.wd3 = data;
    tick();
    bus.we3 = 1'b0;
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return 32'hC000_0000 | (i * 32'h0001_0203);
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus.we3  = 1'b0;
    bus.ra1  = '0;
    bus.ra2  = '0;
    bus.wa3  = '0;
    bus.wd3  = '0;

    // 1: reset clears everything
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ra1 = 5'd5;
    bus.ra2 = 5'd31;
    #1;
    check("reset_rd1_x5", bus.rd1, 32'h0);
    check("reset_rd2_x31", bus.rd2, 32'h0);

    // 2: write then zero-latency read
    write(5'd7, 32'hDEADBEEF);
    bus.ra1 = 5'd7;
    #1;
    check("wr_x7_rd1", bus.rd1, 32'hDEADBEEF);

    // 3: write to x0 ignored
    write(5'd0, 32'hFFFFFFFF);
    bus.ra1 = 5'd0;
    bus.ra2 = 5'd0;
    #1;
    check("x0_rd1", bus.rd1, 32'h0);
    check("x0_rd2", bus.rd2, 32'h0);
    bus.ra1 = 5'd7;
    #1;
    check("x0_wr_no_side_effect", bus.rd1, 32'hDEADBEEF);

    // 4: read-during-write returns the old value until the edge
    write(5'd9, 32'h1);
    bus.ra1 = 5'd9;
    bus.ra2 = 5'd9;
    bus.we3 = 1'b1;
    bus.wa3 = 5'd9;
    bus.wd3 = 32'h2;
    #1;
    check("rdw_before_rd1", bus.rd1, 32'h1);
    check("rdw_before_rd2", bus.rd2, 32'h1);
    tick();
    bus.we3 = 1'b0;
    check("rdw_after_rd1", bus.rd1, 32'h2);
    check("rdw_after_rd2", bus.rd2, 32'h2);

    // 5: we3=0 leaves state unchanged
    write(5'd3, 32'h0000_0055);
    bus.we3 = 1'b0;
    bus.wa3 = 5'd3;
    bus.wd3 = 32'h1234;
    tick();
    bus.ra1 = 5'd3;
    #1;
    check("we_low_x3", bus.rd1, 32'h0000_0055);

    // Full sweep: distinct value per register, read back on both ports
    for (int i = 1; i < 32; i++) write(i[4:0], sweep_val(i));
    for (int i = 1; i < 32; i++) begin
      bus.ra1 = i[4:0];
      bus.ra2 = 5'(32 - i);
      #1;
      check($sformatf("sweep_rd1_x%0d", i), bus.rd1, sweep_val(i));
      check($sformatf("sweep_rd2_x%0d", 32 - i), bus.rd2, sweep_val(32 - i));
    end

    // 6: reset has priority over a write on the same edge
    write(5'd12, 32'hA5A5A5A5);
    bus.ra1 = 5'd12;
    #1;
    check("x12_prior", bus.rd1, 32'hA5A5A5A5);
    reset   = 1'b1;
    bus.we3 = 1'b1;
    bus.wa3 = 5'd12;
    bus.wd3 = 32'h5A5A5A5A;
    tick();
    reset   = 1'b0;
    bus.we3 = 1'b0;
    check("rst_prio_x12", bus.rd1, 32'h0);
    for (int i = 1; i < 32; i++) begin
      bus.ra2 = i[4:0];
      #1;
      check($sformatf("post_rst_x%0d", i), bus.rd2, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
